// File: rtl/if_stage.sv
// if_stage: PC register, instruction-memory fetch control and IF/ID register with stall hold buffer and branch redirect
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSY,
  output logic [31:0] PC_OUT,
  output logic [31:0] PC_PLUS_FOUR_OUT,
  output logic [31:0] INSTRUCTION_OUT,
  output logic        VALID_OUT
);
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DISCARD} state_t;
  state_t state, state_n;
  logic [31:0] pc, req_addr, hold_addr, hold_data;
  logic hold_valid, done, pending;
  assign IMEM_READ = !RESET && !hold_valid;
  assign IMEM_ADDRESS = state == S_FETCH ? pc : req_addr;
  assign done = IMEM_READ && !IMEM_BUSY;
  assign pending = IMEM_READ && IMEM_BUSY;
  // a request still outstanding after this edge keeps the memory port busy: WAIT normally, DISCARD if redirected
  always_comb begin
    state_n = pending ? (BRANCH_TAKEN ? S_DISCARD : (state == S_FETCH ? S_WAIT : state)) : S_FETCH;
  end
  // PC, request address, hold buffer and IF/ID register; redirect beats hold drain, which beats delivery
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      req_addr <= RESET_PC;
      hold_valid <= 1'b0;
      hold_addr <= '0;
      hold_data <= NOP;
      PC_OUT <= '0;
      PC_PLUS_FOUR_OUT <= '0;
      INSTRUCTION_OUT <= NOP;
      VALID_OUT <= 1'b0;
    end else begin
      state <= state_n;
      req_addr <= IMEM_ADDRESS;
      if (BRANCH_TAKEN) begin
        pc <= BRANCH_TARGET & ~32'h3;
        hold_valid <= 1'b0;
        PC_OUT <= '0;
        PC_PLUS_FOUR_OUT <= '0;
        INSTRUCTION_OUT <= NOP;
        VALID_OUT <= 1'b0;
      end else if (hold_valid && !STALL) begin
        hold_valid <= 1'b0;
        PC_OUT <= hold_addr;
        PC_PLUS_FOUR_OUT <= hold_addr + 32'd4;
        INSTRUCTION_OUT <= hold_data;
        VALID_OUT <= 1'b1;
      end else if (done && state != S_DISCARD) begin
        pc <= IMEM_ADDRESS + 32'd4;
        if (STALL) begin
          hold_valid <= 1'b1;
          hold_addr <= IMEM_ADDRESS;
          hold_data <= IMEM_READDATA;
        end else begin
          PC_OUT <= IMEM_ADDRESS;
          PC_PLUS_FOUR_OUT <= IMEM_ADDRESS + 32'd4;
          INSTRUCTION_OUT <= IMEM_READDATA;
          VALID_OUT <= 1'b1;
        end
      end
    end
  end
endmodule
